// File: rtl/arm_const.sv
// ---------------------------------------------------------------------------
// arm_const
// Shared constants and types for the ARM SoC video path.
//   VGA_SCREEN_SIZE : number of 32-bit character cells in the text screen
//   VRAM_ADDR_W     : width of the VRAM byte address
//   vram_wr_state_t : state encoding of the VRAM write arbiter fill FSM
// ---------------------------------------------------------------------------
package arm_const;

    // 80 columns x 30 rows of character cells, one 32-bit word per cell
    localparam int VGA_SCREEN_SIZE = 2400;

    localparam int VRAM_ADDR_W = 14;

    typedef enum logic {
        VW_IDLE,
        VW_FILL
    } vram_wr_state_t;

endpackage

// File: rtl/vram_rr_arb2.sv
// ---------------------------------------------------------------------------
// vram_rr_arb2
// Two-requester round-robin arbiter with a registered last-grant record.
//   clk, rst_n : clock and asynchronous active-low reset
//   req[1:0]   : request lines (bit 0 = requester 0, bit 1 = requester 1)
//   gnt[1:0]   : one-hot grant, combinational from req and last grant
// ---------------------------------------------------------------------------
module vram_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0: requester 0 was granted most recently, 1: requester 1
    logic last_grant;

    // A lone requester always wins; under contention the requester that was
    // not granted last time wins, so neither side waits more than one slot.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b0;
        end else if (|gnt) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// ---------------------------------------------------------------------------
// vram_write_arbiter
// Sole owner of the VRAM write port. Shares it between CPU stores and a
// hardware clear engine that writes one fill word to every screen cell.
//   clk, rst_n           : clock and asynchronous active-low reset
//   cpu_valid/addr/wdata : CPU store request (held stable until cpu_ready)
//   cpu_ready            : request accepted this cycle (combinational)
//   cpu_err              : one-cycle pulse, accepted store was out of range
//   clr_start/clr_value  : start a full-screen fill with the given word
//   clr_busy             : fill in progress
//   clr_done             : one-cycle pulse with the last fill write
//   vram_we/a/wd         : registered VRAM write port
// ---------------------------------------------------------------------------
module vram_write_arbiter
    import arm_const::*;
#(
    parameter int SCREEN_WORDS = VGA_SCREEN_SIZE,
    parameter int ADDR_W       = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    input  logic              clr_start,
    input  logic [31:0]       clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_a,
    output logic [31:0]       vram_wd
);

    localparam int IDX_W = ADDR_W - 2;

    // One extra bit so that SCREEN_WORDS itself (up to 4096) is representable
    localparam logic [IDX_W:0]   SCREEN_WORDS_EXT = (IDX_W + 1)'(SCREEN_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX         = IDX_W'(SCREEN_WORDS - 1);

    vram_wr_state_t    state;
    vram_wr_state_t    next_state;
    logic [IDX_W-1:0]  fill_idx;
    logic [IDX_W-1:0]  next_fill_idx;
    logic [31:0]       fill_value;
    logic [31:0]       next_fill_value;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              cpu_in_range;
    logic              fill_last;

    // Requests are masked while reset is held so that cpu_ready reads 0
    // during reset like every other output. Requester 0 is the CPU,
    // requester 1 the clear engine, which has a slot pending every FILL cycle.
    assign req = {(state == VW_FILL), cpu_valid} & {2{rst_n}};

    vram_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign cpu_ready    = gnt[0];
    assign cpu_in_range = {1'b0, cpu_addr[ADDR_W-1:2]} < SCREEN_WORDS_EXT;
    assign fill_last    = (fill_idx == LAST_IDX);
    assign clr_busy     = (state == VW_FILL);

    // Fill FSM state, fill index and latched fill word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= VW_IDLE;
            fill_idx   <= '0;
            fill_value <= '0;
        end else begin
            state      <= next_state;
            fill_idx   <= next_fill_idx;
            fill_value <= next_fill_value;
        end
    end

    // A start request is only honoured from IDLE, so a second clr_start
    // during a fill (including on its final cycle) neither restarts it nor
    // changes the fill word. The index only advances on granted slots.
    always_comb begin
        next_state      = state;
        next_fill_idx   = fill_idx;
        next_fill_value = fill_value;
        case (state)
            VW_IDLE: begin
                if (clr_start) begin
                    next_state      = VW_FILL;
                    next_fill_idx   = '0;
                    next_fill_value = clr_value;
                end
            end
            VW_FILL: begin
                if (gnt[1]) begin
                    if (fill_last) begin
                        next_state = VW_IDLE;
                    end else begin
                        next_fill_idx = fill_idx + 1'b1;
                    end
                end
            end
            default: begin
                next_state = VW_IDLE;
            end
        endcase
    end

    // Output register: the grant of cycle N appears on the VRAM port in N+1.
    // Out-of-range CPU stores are consumed but only raise cpu_err; address
    // and data hold whenever no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_we  <= 1'b0;
            vram_a   <= '0;
            vram_wd  <= '0;
            cpu_err  <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            vram_we  <= gnt[1] | (gnt[0] & cpu_in_range);
            cpu_err  <= gnt[0] & ~cpu_in_range;
            clr_done <= gnt[1] & fill_last;
            if (gnt[1]) begin
                vram_a  <= {fill_idx, 2'b00};
                vram_wd <= fill_value;
            end else if (gnt[0] && cpu_in_range) begin
                vram_a  <= cpu_addr;
                vram_wd <= cpu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_write_arbiter
// Directed self-checking bench for vram_write_arbiter with an 8-word screen.
// ---------------------------------------------------------------------------
module tb_vram_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_valid;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        clr_start;
    logic [31:0] clr_value;
    logic        clr_busy;
    logic        clr_done;
    logic        vram_we;
    logic [13:0] vram_a;
    logic [31:0] vram_wd;

    int checks = 0;
    int errors = 0;

    vram_write_arbiter #(
        .SCREEN_WORDS (8),
        .ADDR_W       (14)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .vram_we   (vram_we),
        .vram_a    (vram_a),
        .vram_wd   (vram_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [13:0] a, input logic [31:0] d,
                                 input logic s, input logic [31:0] fv);
        cpu_valid = v;
        cpu_addr  = a;
        cpu_wdata = d;
        clr_start = s;
        clr_value = fv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int k;
        int f;
        logic exp_ready;

        // Reset held with a CPU request pending: everything reads 0
        rst_n = 1'b0;
        applyStimulus(1'b1, 14'h0010, 32'h00FF0041, 1'b0, 32'h0);
        #1;
        checkOutput("rst_ready", cpu_ready, 0);
        tick;
        tick;
        checkOutput("rst_we", vram_we, 0);
        checkOutput("rst_a", vram_a, 0);
        checkOutput("rst_wd", vram_wd, 0);
        checkOutput("rst_err", cpu_err, 0);
        checkOutput("rst_busy", clr_busy, 0);
        checkOutput("rst_done", clr_done, 0);
        checkOutput("rst_ready_held", cpu_ready, 0);

        // First CPU write after reset release
        rst_n = 1'b1;
        #1;
        checkOutput("cpu_ready", cpu_ready, 1);
        tick;
        applyStimulus(1'b0, 14'h0010, 32'h00FF0041, 1'b0, 32'h0);
        checkOutput("cpu_we", vram_we, 1);
        checkOutput("cpu_a", vram_a, 32'h0010);
        checkOutput("cpu_wd", vram_wd, 32'h00FF0041);
        tick;
        checkOutput("idle_we", vram_we, 0);
        checkOutput("idle_a_hold", vram_a, 32'h0010);

        // Fill alone
        applyStimulus(1'b0, 14'h0, 32'h0, 1'b1, 32'h00000020);
        tick;
        applyStimulus(1'b0, 14'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("fill_busy_start", clr_busy, 1);
        checkOutput("fill_we_start", vram_we, 0);
        for (int i = 0; i < 8; i++) begin
            tick;
            checkOutput($sformatf("fill_we[%0d]", i), vram_we, 1);
            checkOutput($sformatf("fill_a[%0d]", i), vram_a, 32'(4 * i));
            checkOutput($sformatf("fill_wd[%0d]", i), vram_wd, 32'h00000020);
            checkOutput($sformatf("fill_done[%0d]", i), clr_done, (i == 7) ? 1 : 0);
            checkOutput($sformatf("fill_busy[%0d]", i), clr_busy, (i == 7) ? 0 : 1);
        end
        tick;
        checkOutput("fill_we_after", vram_we, 0);
        checkOutput("fill_done_after", clr_done, 0);

        // Contention: CPU and fill alternate, CPU goes first (fill was last)
        applyStimulus(1'b0, 14'h0, 32'h0, 1'b1, 32'hAAAA5555);
        tick;
        k = 0;
        f = 0;
        for (int c = 0; c < 14; c++) begin
            applyStimulus(k < 6, 14'(4 * k), 32'hC0000000 | 32'(k), 1'b0, 32'h0);
            exp_ready = (c < 12) && (c % 2 == 0);
            #1;
            checkOutput($sformatf("cont_ready[%0d]", c), cpu_ready, exp_ready);
            tick;
            checkOutput($sformatf("cont_we[%0d]", c), vram_we, 1);
            if (exp_ready) begin
                checkOutput($sformatf("cont_cpu_a[%0d]", c), vram_a, 32'(4 * k));
                checkOutput($sformatf("cont_cpu_wd[%0d]", c), vram_wd, 32'hC0000000 | 32'(k));
                k++;
            end else begin
                checkOutput($sformatf("cont_fill_a[%0d]", c), vram_a, 32'(4 * f));
                checkOutput($sformatf("cont_fill_wd[%0d]", c), vram_wd, 32'hAAAA5555);
                f++;
            end
            checkOutput($sformatf("cont_done[%0d]", c), clr_done, (c == 13) ? 1 : 0);
        end
        applyStimulus(1'b0, 14'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("cont_busy_end", clr_busy, 0);

        // Out of range store (index 8), then the highest legal byte address
        applyStimulus(1'b1, 14'h0020, 32'hDEADBEEF, 1'b0, 32'h0);
        #1;
        checkOutput("oor_ready", cpu_ready, 1);
        tick;
        applyStimulus(1'b1, 14'h001F, 32'h12345678, 1'b0, 32'h0);
        checkOutput("oor_we", vram_we, 0);
        checkOutput("oor_err", cpu_err, 1);
        checkOutput("oor_a_hold", vram_a, 32'h001C);
        tick;
        applyStimulus(1'b0, 14'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("edge_err", cpu_err, 0);
        checkOutput("edge_we", vram_we, 1);
        checkOutput("edge_a", vram_a, 32'h001F);
        checkOutput("edge_wd", vram_wd, 32'h12345678);
        tick;
        checkOutput("edge_we_after", vram_we, 0);

        // Reset in the middle of a fill
        applyStimulus(1'b0, 14'h0, 32'h0, 1'b1, 32'h33333333);
        tick;
        applyStimulus(1'b0, 14'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput($sformatf("mid_a[%0d]", i), vram_a, 32'(4 * i));
        end
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_we", vram_we, 0);
        checkOutput("mid_rst_busy", clr_busy, 0);
        checkOutput("mid_rst_done", clr_done, 0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput($sformatf("post_rst_we[%0d]", i), vram_we, 0);
            checkOutput($sformatf("post_rst_busy[%0d]", i), clr_busy, 0);
            checkOutput($sformatf("post_rst_done[%0d]", i), clr_done, 0);
        end

        // Re-trigger during a fill is ignored
        applyStimulus(1'b0, 14'h0, 32'h0, 1'b1, 32'h11111111);
        tick;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 14'h0, 32'h0, i == 3, 32'h22222222);
            tick;
            checkOutput($sformatf("retrig_we[%0d]", i), vram_we, 1);
            checkOutput($sformatf("retrig_a[%0d]", i), vram_a, 32'(4 * i));
            checkOutput($sformatf("retrig_wd[%0d]", i), vram_wd, 32'h11111111);
            checkOutput($sformatf("retrig_done[%0d]", i), clr_done, (i == 7) ? 1 : 0);
        end
        applyStimulus(1'b0, 14'h0, 32'h0, 1'b0, 32'h0);
        tick;
        checkOutput("retrig_we_after", vram_we, 0);
        checkOutput("retrig_done_after", clr_done, 0);
        checkOutput("retrig_busy_after", clr_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Sole owner of the VRAM write port (clk, we, a[13:0], wd[31:0]; word index = a[13:2]).
- Shares that port between the CPU store path and a built-in hardware clear engine that fills every screen word with one value.
- Sits between the memory-mapped bus decode and VRAM. Registered outputs give VRAM a clean, single-source write each cycle.

Parameters:
- SCREEN_WORDS, default VGA_SCREEN_SIZE (from arm_const); number of 32-bit VRAM words. Legal range 1..4096.
- ADDR_W, default 14; width of the VRAM byte address.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_valid  in  1  CPU write request
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  32  CPU write data (ASCII in [7:0], colour in upper bits)
- cpu_ready  out  1  request accepted this cycle (combinational)
- cpu_err  out  1  one-cycle pulse: accepted request was out of range and dropped
- clr_start  in  1  start a full-screen fill
- clr_value  in  32  fill word; sampled on the accepted clr_start
- clr_busy  out  1  fill in progress
- clr_done  out  1  one-cycle pulse after the last fill write is issued
- vram_we  out  1  to VRAM we
- vram_a  out  ADDR_W  to VRAM a
- vram_wd  out  32  to VRAM wd

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM state=IDLE; fill index=0; last_grant=CPU; latched fill value=0. Asserting reset mid-fill aborts the fill and does not pulse clr_done.
- FSM states:
  - IDLE: clr_start=1 -> FILL. Latch clr_value, index←0, clr_busy←1 on the same edge.
  - FILL: a fill slot is pending every cycle.
    - Granted slot with index=SCREEN_WORDS-1 -> IDLE; clr_busy←0; clr_done pulses 1 cycle.
    - Any other granted slot: index increments by 1.
- clr_start while in FILL is ignored. No restart, no value change.
- Arbitration, evaluated each cycle:
  - Only one source pending: that source wins.
  - Both pending (cpu_valid=1 and state=FILL): round-robin. The winner is the source not recorded in last_grant; last_grant updates on every grant.
  - Result: the CPU waits at most 1 cycle; the fill takes at most 2*SCREEN_WORDS cycles under continuous CPU traffic.
- cpu_ready = cpu_valid & CPU wins. The CPU must hold valid, addr and data stable until ready=1.
- Output register (latency 1): a grant in cycle N produces vram_we/a/wd in cycle N+1.
  - CPU write: a = cpu_addr unmodified (low 2 bits passed through); wd = cpu_wdata.
  - Fill write: a = {index, 2'b00} zero-extended to ADDR_W; wd = latched fill value.
  - No grant: vram_we=0; vram_a and vram_wd hold their previous values.
- Range check: if cpu_addr[ADDR_W-1:2] >= SCREEN_WORDS, the request is still accepted (ready=1) but produces vram_we=0. cpu_err pulses in cycle N+1.
- cpu_err and clr_done are never asserted for more than one cycle.
- Simultaneous events:
  - clr_start in IDLE together with cpu_valid: the CPU is granted that cycle; the fill begins competing next cycle.
  - Fill completion together with a new clr_start: clr_start is ignored (state is FILL during that cycle).

Decomposition:
- arm_const gains VRAM_ADDR_W=14 and typedef enum logic {VW_IDLE, VW_FILL} vram_wr_state_t.
- VGA_SCREEN_SIZE is reused from arm_const.
- One natural sub-module: vram_rr_arb2, a 2-requester round-robin arbiter (req[1:0], gnt[1:0], last-grant flop on clk/rst_n). The FSM, fill counter and output register stay in the top module.

Test Plan (SCREEN_WORDS=8 override unless stated):
- Reset: hold rst_n=0 with cpu_valid=1 -> all outputs 0. Release, CPU write addr=0x0010, data=0x00FF0041 -> ready same cycle; next cycle we=1, a=0x0010, wd=0x00FF0041.
- Fill alone: clr_start=1, clr_value=0x00000020 -> we=1 for 8 consecutive cycles with a=0x0000,0x0004,…,0x001C; clr_done pulses once; clr_busy=0 afterwards.
- Contention: fill running with cpu_valid held high for 6 cycles -> grants alternate CPU/fill. The CPU never waits >1 cycle; all 8 fill words are still written exactly once.
- Out of range: cpu_addr=0x0020 (index 8) -> ready=1; next cycle we=0 and cpu_err=1 for one cycle.
- Reset mid-fill: assert rst_n=0 after 3 fill writes -> we, clr_busy and clr_done drop to 0 immediately. After release, the FSM is IDLE and no further writes occur.
- Re-trigger: clr_start pulsed again during FILL -> ignored; exactly 8 writes occur and clr_done pulses once.
